// File: rtl/req_dispatch_pkg.sv
// Shared definitions for the req_dispatch8 capture-and-dispatch stage.
//   state_t    : FSM states (IDLE, GRANT)
//   NREQ       : number of request lines
//   CODE_W     : width of the granted-index code
//   popcount8  : number of set bits in an 8-bit vector (0..8)
package req_dispatch_pkg;

    localparam int NREQ   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pri_enc8.sv
// 8-to-3 priority encoder, purely combinational.
//   vec  : input  [7:0] request vector, bit 7 highest priority
//   code : output [2:0] 7 - index of highest set bit (bit 7 -> 000, bit 0 -> 111);
//          000 when vec is zero (callers never use that case)
module pri_enc8
    import req_dispatch_pkg::*;
(
    input  logic [NREQ-1:0]   vec,
    output logic [CODE_W-1:0] code
);

    // Ascending scan: the last (highest) set bit seen wins.
    always_comb begin
        code = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (vec[i]) begin
                code = CODE_W'(NREQ - 1 - i);
            end
        end
    end

endmodule

// File: rtl/req_dispatch8.sv
// Capture-and-dispatch stage for eight request lines.
// Request pulses latch into a sticky pending vector; the highest-priority
// pending request is presented as a 3-bit code with a valid/ack handshake,
// and its bit is cleared on acknowledge. Requests arriving on a line that is
// already pending (and not being cleared this cycle) are counted as dropped.
//   clk      : input          rising-edge clock
//   rst      : input          asynchronous active-high reset
//   req      : input  [7:0]   request pulses, bit 7 highest priority
//   ack      : input          consumer accepts the presented code (while valid)
//   valid    : output         code holds a granted request
//   code     : output [2:0]   granted index, bit 7 -> 000 ... bit 0 -> 111
//   pending  : output [7:0]   sticky pending vector
//   drop_cnt : output [DROP_W-1:0] saturating dropped-request count
module req_dispatch8
    import req_dispatch_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic              ack,
    output logic              valid,
    output logic [CODE_W-1:0] code,
    output logic [NREQ-1:0]   pending,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_t            state;
    state_t            state_next;
    logic [NREQ-1:0]   clr;
    logic [CODE_W-1:0] enc_code;
    logic [3:0]        drops;
    logic [DROP_W+3:0] drop_sum;

    pri_enc8 u_enc (
        .vec  (pending),
        .code (enc_code)
    );

    // Code 0 maps to bit 7, so the one-hot clear is a right shift of the MSB.
    always_comb begin
        clr = '0;
        if (state == GRANT && ack) begin
            clr = 8'h80 >> code;
        end
    end

    assign drops    = popcount8(req & pending & ~clr);
    assign drop_sum = {4'b0000, drop_cnt} + {{DROP_W{1'b0}}, drops};

    // Pending register: set wins over clear on the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | req;
        end
    end

    // Dropped-request counter, sum computed 4 bits wider so saturation is exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_sum > {4'b0000, DROP_MAX}) begin
            drop_cnt <= DROP_MAX;
        end else begin
            drop_cnt <= drop_sum[DROP_W-1:0];
        end
    end

    // Code register: loaded only when leaving IDLE, frozen through GRANT,
    // holds its last value afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code <= '0;
        end else if (state == IDLE && pending != '0) begin
            code <= enc_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                valid = 1'b1;
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
